// File: rtl/sobel_edge_detect.sv
// Sobel 3x3 edge detector: 4-stage pipeline producing one edge pixel per valid window.
// Define SOBEL_GRAY_OUT_EN for a saturated grey-level magnitude output instead of the binary edge.
module sobel_edge_detect #(
    parameter int unsigned COL       = 30,
    parameter int unsigned ROW       = 30,
    parameter int unsigned THRESHOLD = 100
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       valid_in,
    input  logic [7:0] matrix_11,
    input  logic [7:0] matrix_12,
    input  logic [7:0] matrix_13,
    input  logic [7:0] matrix_21,
    input  logic [7:0] matrix_22,
    input  logic [7:0] matrix_23,
    input  logic [7:0] matrix_31,
    input  logic [7:0] matrix_32,
    input  logic [7:0] matrix_33,
    output logic [7:0] dout,
    output logic       valid_out,
    output logic       eol,
    output logic       frame_done
);

    localparam int CW = (COL > 1) ? $clog2(COL) : 1;
    localparam int RW = (ROW > 1) ? $clog2(ROW) : 1;
    localparam logic [CW-1:0] COL_LAST = CW'(COL - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(ROW - 1);

    logic [3:0]    vld_q, vld_d;
    logic [9:0]    gx_p_q, gx_p_d, gx_n_q, gx_n_d;
    logic [9:0]    gy_p_q, gy_p_d, gy_n_q, gy_n_d;
    logic [9:0]    abs_gx_q, abs_gx_d, abs_gy_q, abs_gy_d;
    logic [10:0]   mag_q, mag_d;
    logic [7:0]    dout_q, dout_d;
    logic [CW-1:0] col_q, col_d;
    logic [RW-1:0] row_q, row_d;

    // a + 2b + c, widened to 10 bits so the worst case (1020) fits
    function automatic logic [9:0] wsum(input logic [7:0] a, input logic [7:0] b,
                                        input logic [7:0] c);
        return {2'b00, a} + {1'b0, b, 1'b0} + {2'b00, c};
    endfunction

    function automatic logic [9:0] absdiff(input logic [9:0] p, input logic [9:0] n);
        return (p >= n) ? (p - n) : (n - p);
    endfunction

    always_comb begin
        vld_d    = {vld_q[2:0], valid_in};
        gx_p_d   = gx_p_q;
        gx_n_d   = gx_n_q;
        gy_p_d   = gy_p_q;
        gy_n_d   = gy_n_q;
        abs_gx_d = abs_gx_q;
        abs_gy_d = abs_gy_q;
        mag_d    = mag_q;
        dout_d   = dout_q;
        col_d    = col_q;
        row_d    = row_q;

        if (valid_in) begin
            gx_p_d = wsum(matrix_13, matrix_23, matrix_33);
            gx_n_d = wsum(matrix_11, matrix_21, matrix_31);
            gy_p_d = wsum(matrix_31, matrix_32, matrix_33);
            gy_n_d = wsum(matrix_11, matrix_12, matrix_13);
        end

        if (vld_q[0]) begin
            abs_gx_d = absdiff(gx_p_q, gx_n_q);
            abs_gy_d = absdiff(gy_p_q, gy_n_q);
        end

        if (vld_q[1]) begin
            mag_d = {1'b0, abs_gx_q} + {1'b0, abs_gy_q};
        end

        if (vld_q[2]) begin
`ifdef SOBEL_GRAY_OUT_EN
            dout_d = (mag_q > 11'd255) ? 8'd255 : mag_q[7:0];
`else
            // 32-bit compare so thresholds above the 11-bit range still work
            dout_d = ({21'd0, mag_q} >= 32'(THRESHOLD)) ? 8'd255 : 8'd0;
`endif
        end

        if (vld_q[3]) begin
            if (col_q == COL_LAST) begin
                col_d = '0;
                row_d = (row_q == ROW_LAST) ? '0 : row_q + RW'(1);
            end else begin
                col_d = col_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q    <= '0;
            gx_p_q   <= '0;
            gx_n_q   <= '0;
            gy_p_q   <= '0;
            gy_n_q   <= '0;
            abs_gx_q <= '0;
            abs_gy_q <= '0;
            mag_q    <= '0;
            dout_q   <= '0;
            col_q    <= '0;
            row_q    <= '0;
        end else begin
            vld_q    <= vld_d;
            gx_p_q   <= gx_p_d;
            gx_n_q   <= gx_n_d;
            gy_p_q   <= gy_p_d;
            gy_n_q   <= gy_n_d;
            abs_gx_q <= abs_gx_d;
            abs_gy_q <= abs_gy_d;
            mag_q    <= mag_d;
            dout_q   <= dout_d;
            col_q    <= col_d;
            row_q    <= row_d;
        end
    end

    assign dout       = dout_q;
    assign valid_out  = vld_q[3];
    assign eol        = vld_q[3] && (col_q == COL_LAST);
    assign frame_done = eol && (row_q == ROW_LAST);

endmodule

// File: tb/tb_sobel_edge_detect.sv
// Self-checking bench for sobel_edge_detect: table vectors plus randomized frames
// checked against a kernel-convolution reference and a delay-queue output model.
module tb_sobel_edge_detect;

    localparam int COL = 30;
    localparam int ROW = 30;
    localparam int THR = 100;
    localparam int NPIX = COL * ROW;

    typedef logic [8:0][7:0] win_t;   // index = row*3 + col, row 0 top, col 0 left
    typedef struct packed { logic v; logic [7:0] d; } exp_t;
    typedef struct { string name; win_t w; logic [7:0] e; } vec_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       valid_in = 1'b0;
    win_t       cur_w = '0;
    logic [7:0] dout;
    logic       valid_out, eol, frame_done;

    int   errors = 0;
    int   checks = 0;
    int   out_cnt = 0;
    logic [7:0] last_dout = 8'd0;
    int   vo_seen, eol_seen, fd_seen, fd_at;
    exp_t pipe[$];
    win_t frame_w[NPIX];
    logic frame_b[NPIX * 2];
    vec_t tbl[6];

    sobel_edge_detect #(.COL(COL), .ROW(ROW), .THRESHOLD(THR)) dut (
        .clk(clk), .rst_n(rst_n), .valid_in(valid_in),
        .matrix_11(cur_w[0]), .matrix_12(cur_w[1]), .matrix_13(cur_w[2]),
        .matrix_21(cur_w[3]), .matrix_22(cur_w[4]), .matrix_23(cur_w[5]),
        .matrix_31(cur_w[6]), .matrix_32(cur_w[7]), .matrix_33(cur_w[8]),
        .dout(dout), .valid_out(valid_out), .eol(eol), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    function automatic int iabs(input int x);
        return (x < 0) ? -x : x;
    endfunction

    function automatic logic [7:0] ref_dout(input win_t w);
        int kx[9];
        int ky[9];
        int gx, gy, mag;
        kx = '{-1, 0, 1, -2, 0, 2, -1, 0, 1};
        ky = '{-1, -2, -1, 0, 0, 0, 1, 2, 1};
        gx = 0;
        gy = 0;
        for (int i = 0; i < 9; i++) begin
            gx += kx[i] * int'(w[i]);
            gy += ky[i] * int'(w[i]);
        end
        mag = iabs(gx) + iabs(gy);
`ifdef SOBEL_GRAY_OUT_EN
        return (mag > 255) ? 8'd255 : 8'(mag);
`else
        return (mag >= THR) ? 8'd255 : 8'd0;
`endif
    endfunction

    function automatic win_t cols(input logic [7:0] l, input logic [7:0] m, input logic [7:0] r);
        win_t w;
        for (int rr = 0; rr < 3; rr++) begin
            w[rr*3 + 0] = l;
            w[rr*3 + 1] = m;
            w[rr*3 + 2] = r;
        end
        return w;
    endfunction

    // Half the windows are smooth (small gradients) so both outcomes occur often.
    function automatic win_t rand_win();
        win_t w;
        int base;
        base = $urandom_range(0, 200);
        for (int i = 0; i < 9; i++) begin
            if ($urandom_range(0, 1) == 0) w[i] = 8'($urandom_range(0, 255));
            else w[i] = 8'(base + $urandom_range(0, 20));
        end
        return w;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // One clock: present inputs, step the delay-queue model, compare outputs.
    task automatic cycle(input logic v, input win_t w, input logic [7:0] e);
        exp_t cur;
        logic exp_eol, exp_fd;
        valid_in = v;
        cur_w = w;
        pipe.push_back('{v: v, d: e});
        @(posedge clk);
        #1;
        cur = pipe.pop_front();
        exp_eol = 1'b0;
        exp_fd  = 1'b0;
        if (cur.v) begin
            exp_eol = ((out_cnt % COL) == COL - 1);
            exp_fd  = exp_eol && (((out_cnt / COL) % ROW) == ROW - 1);
            last_dout = cur.d;
            out_cnt++;
        end
        chk("valid_out", int'(valid_out), int'(cur.v));
        chk("dout", int'(dout), int'(last_dout));
        chk("eol", int'(eol), int'(exp_eol));
        chk("frame_done", int'(frame_done), int'(exp_fd));
        if (valid_out) vo_seen++;
        if (eol) eol_seen++;
        if (frame_done) begin
            fd_seen++;
            fd_at = vo_seen;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, '0, 8'd0);
    endtask

    task automatic chk_zero_outputs(input string tag);
        chk({tag, "_valid_out"}, int'(valid_out), 0);
        chk({tag, "_dout"}, int'(dout), 0);
        chk({tag, "_eol"}, int'(eol), 0);
        chk({tag, "_frame_done"}, int'(frame_done), 0);
    endtask

    // Called just after a rising edge; valid_in is held high to show it is ignored.
    task automatic reset_dut(input int ncyc);
        rst_n = 1'b0;
        valid_in = 1'b1;
        cur_w = cols(8'd0, 8'd0, 8'd255);
        #1;
        chk_zero_outputs("rst_async");
        for (int i = 0; i < ncyc; i++) begin
            @(posedge clk);
            #1;
            chk_zero_outputs("rst_hold");
        end
        rst_n = 1'b1;
        valid_in = 1'b0;
        pipe.delete();
        for (int i = 0; i < 3; i++) pipe.push_back('{v: 1'b0, d: 8'd0});
        out_cnt = 0;
        last_dout = 8'd0;
    endtask

    task automatic clear_tallies();
        vo_seen = 0;
        eol_seen = 0;
        fd_seen = 0;
        fd_at = -1;
    endtask

    // Sends NPIX windows with random bubbles; stop_vo > 0 returns early once that
    // many outputs have been seen (used for the mid-frame reset).
    task automatic run_frame(input bit replay, input int stop_vo);
        int sent, guard, bi;
        sent = 0;
        guard = 0;
        bi = 0;
        while (sent < NPIX && guard < 3 * NPIX) begin
            logic bubble;
            guard++;
            if (replay) bubble = frame_b[bi % (NPIX * 2)];
            else begin
                bubble = ($urandom_range(0, 9) < 3);
                frame_b[bi % (NPIX * 2)] = bubble;
            end
            bi++;
            if (bubble) cycle(1'b0, rand_win(), 8'd0);
            else begin
                if (!replay) frame_w[sent] = rand_win();
                cycle(1'b1, frame_w[sent], ref_dout(frame_w[sent]));
                sent++;
            end
            if (stop_vo > 0 && vo_seen >= stop_vo) return;
        end
        if (sent < NPIX) chk("frame_budget", sent, NPIX);
        idle(6);
    endtask

    task automatic chk_frame(input string tag);
        chk({tag, "_valid_count"}, vo_seen, NPIX);
        chk({tag, "_eol_count"}, eol_seen, ROW);
        chk({tag, "_frame_done_count"}, fd_seen, 1);
        chk({tag, "_frame_done_index"}, fd_at, NPIX);
    endtask

    initial begin
        win_t w;
        tbl[0] = '{"uniform", cols(8'd128, 8'd128, 8'd128), 8'd0};
        tbl[1] = '{"vert_edge", cols(8'd0, 8'd77, 8'd255), 8'd255};
        w = '0;
        w[0] = 8'd255;
`ifdef SOBEL_GRAY_OUT_EN
        tbl[2] = '{"thr_25", cols(8'd0, 8'd9, 8'd25), 8'd100};
        tbl[3] = '{"thr_24", cols(8'd0, 8'd9, 8'd24), 8'd96};
`else
        tbl[2] = '{"thr_25", cols(8'd0, 8'd9, 8'd25), 8'd255};
        tbl[3] = '{"thr_24", cols(8'd0, 8'd9, 8'd24), 8'd0};
`endif
        tbl[4] = '{"diagonal", w, 8'd255};
        tbl[5] = '{"uniform_again", cols(8'd3, 8'd3, 8'd3), 8'd0};

        clear_tallies();
        @(posedge clk);
        #1;
        reset_dut(2);

        // Isolated windows: one valid, then bubbles so dout must hold.
        for (int i = 0; i < 6; i++) begin
            cycle(1'b1, tbl[i].w, tbl[i].e);
            idle(5);
        end
        // Same vectors back to back.
        for (int i = 0; i < 6; i++) cycle(1'b1, tbl[i].w, tbl[i].e);
        idle(5);
        chk("table_valid_count", vo_seen, 12);

        // Two full frames, the second a replay of the first.
        reset_dut(1);
        clear_tallies();
        run_frame(1'b0, 0);
        chk_frame("frame1");
        clear_tallies();
        run_frame(1'b1, 0);
        chk_frame("frame2");

        // Reset mid-frame after 47 outputs; in-flight windows must vanish.
        reset_dut(1);
        clear_tallies();
        run_frame(1'b0, 47);
        chk("prereset_valid_count", vo_seen, 47);
        reset_dut(3);
        clear_tallies();
        run_frame(1'b0, 0);
        chk_frame("post_reset");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
